// File: rtl/bus_op_pkg.sv
// Shared select codes, FSM state and bus direction types for the bus op sequencer.
package bus_op_pkg;

    localparam logic [1:0] SEL_IDLE   = 2'b00;
    localparam logic [1:0] SEL_LOAD   = 2'b01;
    localparam logic [1:0] SEL_DRIVE  = 2'b10;
    localparam logic [1:0] SEL_SAMPLE = 2'b11;

    typedef enum logic [1:0] {IDLE, TURN, ISSUE, WAIT} state_t;

    typedef enum logic [1:0] {NONE, DRIVE, READ} dir_t;

    // True when issuing op would reverse the bus direction last used.
    function automatic logic needs_turn(input logic [1:0] op, input dir_t last_dir);
        return ((op == SEL_DRIVE) && (last_dir == READ)) ||
               ((op == SEL_SAMPLE) && (last_dir == DRIVE));
    endfunction

endpackage

// File: rtl/bus_op_sequencer_rr_arbiter.sv
// Round-robin pick among eligible requesters; the search starts at the
// pointer, which moves just past the index reported on the update strobe.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] eligible,
    input  logic            update,
    input  logic [IW-1:0]   upd_idx,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    logic [IW-1:0] ptr;

    // Pointer advances to one past the issued requester, wrapping at NREQ.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (update)
            ptr <= (int'(upd_idx) == NREQ - 1) ? '0 : upd_idx + 1'b1;
    end

    // First eligible index at or after the pointer, modulo NREQ.
    always_comb begin
        any     = 1'b0;
        win_idx = '0;
        winner  = '0;
        for (int off = 0; off < NREQ; off++) begin
            int idx;
            idx = (int'(ptr) + off) % NREQ;
            if (!any && eligible[idx]) begin
                any     = 1'b1;
                win_idx = IW'(idx);
            end
        end
        if (any)
            winner[win_idx] = 1'b1;
    end

endmodule

// File: rtl/bus_op_sequencer.sv
// Shares the bus datapath among NREQ requesters: arbitrates, issues one
// select per op, inserts turnaround idles on direction reversal and returns
// captured dtoe to the requester that issued the load/sample.
module bus_op_sequencer
    import bus_op_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int W           = 4,
    parameter int TURN_CYCLES = 1,
    localparam int IW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] op,
    input  logic [W*NREQ-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [1:0]        select,
    output logic [W-1:0]      etod,
    input  logic [W-1:0]      dtoe,
    output logic              rvalid,
    output logic [W-1:0]      rdata,
    output logic [IW-1:0]     rid
);

    localparam logic [1:0] TURN_INIT = (TURN_CYCLES > 0) ? 2'(TURN_CYCLES - 1) : 2'd0;

    state_t          state, state_d;
    dir_t            last_dir;
    logic [IW-1:0]   cur_k, issue_k;
    logic [1:0]      turn_cnt;
    logic [NREQ-1:0] eligible, win_oh, gnt_d;
    logic [IW-1:0]   win_idx;
    logic            any, enter_issue;
    logic [1:0]      win_op;

    // A request with op 00 is not a request at all.
    always_comb begin
        for (int i = 0; i < NREQ; i++)
            eligible[i] = req[i] && (op[2*i +: 2] != SEL_IDLE);
    end

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible),
        .update   (state == ISSUE),
        .upd_idx  (cur_k),
        .winner   (win_oh),
        .win_idx  (win_idx),
        .any      (any)
    );

    assign win_op = op[2*int'(win_idx) +: 2];

    // Next state; from TURN the locked winner is issued, not a fresh pick.
    always_comb begin
        state_d = state;
        issue_k = cur_k;
        gnt_d   = '0;
        unique case (state)
            IDLE: begin
                issue_k = win_idx;
                gnt_d   = win_oh;
                if (any)
                    state_d = (TURN_CYCLES > 0 && needs_turn(win_op, last_dir)) ? TURN : ISSUE;
            end
            TURN: begin
                gnt_d[cur_k] = 1'b1;
                if (turn_cnt == 2'd0)
                    state_d = ISSUE;
            end
            ISSUE:   state_d = (select == SEL_DRIVE) ? IDLE : WAIT;
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        enter_issue = (state_d == ISSUE) && (state != ISSUE);
    end

    // State, registered outputs and direction tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_dir <= NONE;
            cur_k    <= '0;
            turn_cnt <= '0;
            select   <= SEL_IDLE;
            etod     <= '0;
            gnt      <= '0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rid      <= '0;
        end else begin
            state  <= state_d;
            select <= SEL_IDLE;
            gnt    <= '0;
            rvalid <= 1'b0;
            if (state == IDLE && any) begin
                cur_k    <= win_idx;
                turn_cnt <= TURN_INIT;
            end
            if (state == TURN)
                turn_cnt <= turn_cnt - 1'b1;
            if (enter_issue) begin
                select <= op[2*int'(issue_k) +: 2];
                etod   <= wdata[W*int'(issue_k) +: W];
                gnt    <= gnt_d;
            end
            if (state == ISSUE) begin
                if (select == SEL_DRIVE)
                    last_dir <= DRIVE;
                else if (select == SEL_SAMPLE)
                    last_dir <= READ;
            end
            if (state == WAIT) begin
                rdata  <= dtoe;
                rid    <= cur_k;
                rvalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_op_sequencer.sv
// Directed bench for bus_op_sequencer (NREQ=4, W=4, TURN_CYCLES=1) with a
// small registered datapath model closing the etod/dtoe loop.
module tb_bus_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  select;
    logic [3:0]  etod;
    logic [3:0]  dtoe;
    logic        rvalid;
    logic [3:0]  rdata;
    logic [1:0]  rid;
    logic [3:0]  bus_ext;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_op_sequencer #(.NREQ(4), .W(4), .TURN_CYCLES(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .op     (op),
        .wdata  (wdata),
        .gnt    (gnt),
        .select (select),
        .etod   (etod),
        .dtoe   (dtoe),
        .rvalid (rvalid),
        .rdata  (rdata),
        .rid    (rid)
    );

    // Datapath model: load copies etod, sample copies the external bus driver.
    always_ff @(posedge clk) begin
        if (rst)
            dtoe <= '0;
        else if (select == 2'b01)
            dtoe <= etod;
        else if (select == 2'b11)
            dtoe <= bus_ext;
    end

    typedef struct {
        int         idx;
        logic [1:0] op;
        logic [3:0] wd;
        logic [3:0] busv;
        int         lat;
        logic [3:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts falling edges until gnt appears, giving up after 8.
    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 4'b0 && n < 8);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        op = '0;
        wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        req = '0;
        op = '0;
        req[v.idx] = 1'b1;
        op[2*v.idx +: 2] = v.op;
        wdata[4*v.idx +: 4] = v.wd;
        bus_ext = v.busv;
        wait_gnt(n);
        chk("latency", n, v.lat);
        chk("gnt", {28'b0, gnt}, 32'(1) << v.idx);
        chk("select", {30'b0, select}, {30'b0, v.op});
        chk("etod", {28'b0, etod}, {28'b0, v.wd});
        req = '0;
        @(negedge clk);
        chk("select_after_issue", {30'b0, select}, 0);
        if (v.op != 2'b10) begin
            chk("rvalid_in_wait", {31'b0, rvalid}, 0);
            @(negedge clk);
            chk("rvalid", {31'b0, rvalid}, 1);
            chk("rdata", {28'b0, rdata}, {28'b0, v.exp_rd});
            chk("rid", {30'b0, rid}, v.idx);
        end
    endtask

    initial begin
        int n;
        bus_ext = '0;
        // idx, op, wdata, bus, latency to gnt, expected rdata
        vecs[0] = '{0, 2'b01, 4'hA, 4'h0, 1, 4'hA};
        vecs[1] = '{1, 2'b10, 4'h5, 4'h0, 1, 4'h0};
        vecs[2] = '{2, 2'b11, 4'h0, 4'h3, 2, 4'h3};
        vecs[3] = '{3, 2'b11, 4'h1, 4'hC, 1, 4'hC};
        vecs[4] = '{1, 2'b10, 4'h7, 4'h0, 2, 4'h0};
        vecs[5] = '{0, 2'b01, 4'h9, 4'h0, 1, 4'h9};
        vecs[6] = '{2, 2'b11, 4'h2, 4'h6, 2, 4'h6};
        vecs[7] = '{3, 2'b10, 4'hF, 4'h0, 2, 4'h0};

        do_reset();
        chk("rst_select", {30'b0, select}, 0);
        chk("rst_etod", {28'b0, etod}, 0);
        chk("rst_gnt", {28'b0, gnt}, 0);
        chk("rst_rvalid", {31'b0, rvalid}, 0);
        chk("rst_rdata", {28'b0, rdata}, 0);
        chk("rst_rid", {30'b0, rid}, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // op 00 with req held is never granted.
        req = 4'b0100;
        op = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("op00_gnt", {28'b0, gnt}, 0);
            chk("op00_select", {30'b0, select}, 0);
        end

        // All four hold load requests: grants rotate 0,1,2,3,0.
        do_reset();
        req = 4'hF;
        op = 8'b01_01_01_01;
        wdata = {4'd3, 4'd2, 4'd1, 4'd0};
        for (int g = 0; g < 5; g++) begin
            wait_gnt(n);
            chk("rr_gnt", {28'b0, gnt}, 32'(1) << (g % 4));
            @(negedge clk);
            @(negedge clk);
            chk("rr_rvalid", {31'b0, rvalid}, 1);
            chk("rr_rid", {30'b0, rid}, g % 4);
            chk("rr_rdata", {28'b0, rdata}, g % 4);
        end
        req = '0;
        @(negedge clk);

        // Reset during WAIT drops the capture and restores the pointer.
        do_reset();
        req = 4'b0010;
        op = 8'b00_00_01_00;
        wdata = 16'h00B0;
        wait_gnt(n);
        chk("mid_gnt", {28'b0, gnt}, 4'b0010);
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rvalid", {31'b0, rvalid}, 0);
        chk("mid_select", {30'b0, select}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rvalid_after", {31'b0, rvalid}, 0);
        req = 4'hF;
        op = 8'b01_01_01_01;
        wait_gnt(n);
        chk("mid_next_gnt", {28'b0, gnt}, 4'b0001);
        req = '0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
